// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : alu_seq_pkg                                                   |
// | Purpose  : Shared opcode constants, opcode type and sequencer state type |
// |            for the accumulator-based ALU command sequencer.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package alu_seq_pkg;

   typedef logic [2:0] op_t;

   // Opcode meaning belongs to the ALU; the sequencer passes these through.
   localparam op_t OP_ADD  = 3'b000;
   localparam op_t OP_SUB  = 3'b001;
   localparam op_t OP_ADD1 = 3'b010;
   localparam op_t OP_SUB1 = 3'b011;
   localparam op_t OP_AND  = 3'b100;
   localparam op_t OP_OR   = 3'b101;
   localparam op_t OP_XOR  = 3'b110;
   localparam op_t OP_NOT  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : alu_sequencer_if                                              |
// | Purpose  : Command (valid/ready) and response (valid/ready) channels of   |
// |            the ALU sequencer.                                            |
// | Ports    : master - front end: drives cmd_*, rsp_ready                   |
// |            slave  - sequencer: drives cmd_ready, rsp_*                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
interface alu_sequencer_if
   import alu_seq_pkg::*;
#(
   parameter int NBITS = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   op_t              cmd_op;
   logic [NBITS-1:0] cmd_operand;
   logic             cmd_clr;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [NBITS-1:0] rsp_result;
   logic             rsp_carry;

   modport master (
      output cmd_valid, cmd_op, cmd_operand, cmd_clr, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_carry
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_operand, cmd_clr, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_carry
   );
endinterface : alu_sequencer_if
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : alu_sequencer                                                 |
// | Purpose  : Accumulator-based command sequencer. Accepts one command,     |
// |            drives registered operands/opcode to an external combinational|
// |            ALU for SETTLE_CYCLES cycles, captures the result into the    |
// |            accumulator and returns it on the response channel.           |
// | Ports    : clk, rst_n      - clock, async active-low reset               |
// |            bus (slave)     - cmd_* in / rsp_* out handshake channels     |
// |            alu_a/b/op      - registered ALU inputs                       |
// |            alu_q, alu_c    - ALU result and carry fed back               |
// |            busy            - high whenever not IDLE                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NBITS         = 4,
   parameter int SETTLE_CYCLES = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   alu_sequencer_if.slave   bus,
   output logic [NBITS-1:0] alu_a,
   output logic [NBITS-1:0] alu_b,
   output op_t              alu_op,
   input  logic [NBITS:0]   alu_q,
   input  logic             alu_c,
   output logic             busy
);

   // Counter only ever holds SETTLE_CYCLES-1 down to 0; keep at least 1 bit.
   localparam int              CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [NBITS-1:0]   r_acc;
   logic               r_carry;
   logic [NBITS-1:0]   r_alu_a;
   logic [NBITS-1:0]   r_alu_b;
   op_t                r_alu_op;

   logic               w_accept;
   logic               w_capture;
   logic               w_cmd_ready;
   logic               w_rsp_valid;
   logic               w_busy;

   // Result MSB duplicates alu_c; carry is taken from alu_c.
   logic               w_unused_q_msb;
   assign w_unused_q_msb = alu_q[NBITS];

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and handshake outputs
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_busy      = 1'b1;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cmd_ready = 1'b1;
            w_busy      = 1'b0;
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = bus.cmd_clr ? RESP : DRIVE;
            end
         end
         DRIVE: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath: ALU input registers, settle counter, accumulator and carry
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= OP_ADD;
      end else begin
         if (w_accept) begin
            if (bus.cmd_clr) begin
               // Clear leaves the ALU inputs untouched.
               r_acc   <= '0;
               r_carry <= 1'b0;
            end else begin
               r_alu_a  <= r_acc;
               r_alu_b  <= bus.cmd_operand;
               r_alu_op <= bus.cmd_op;
               r_cnt    <= C_CNT_LOAD;
            end
         end
         if (w_capture) begin
            r_acc   <= alu_q[NBITS-1:0];
            r_carry <= alu_c;
         end else if (r_state == DRIVE) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign bus.cmd_ready  = w_cmd_ready;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_result = r_acc;
   assign bus.rsp_carry  = r_carry;
   assign alu_a          = r_alu_a;
   assign alu_b          = r_alu_b;
   assign alu_op         = r_alu_op;
   assign busy           = w_busy;

endmodule : alu_sequencer
`default_nettype wire
